// File: rtl/mem_access_unit_if.sv
// Bus bundle between the EX/MEM pipeline side, the load/store unit and data_mem.
//   Requests : mem_read, mem_write, funct3, addr, store_data
//   Responses: stall (combinational), load_data, load_valid, access_fault (registered)
//   data_mem : dm_r_enable, dm_w_enable, dm_address, dm_wr_data, dm_re_data
// The slave modport is taken by mem_access_unit. The master modport is taken by
// the pipeline side together with the data_mem model, which supplies dm_re_data.
interface mem_access_unit_if;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        stall;
    logic [31:0] load_data;
    logic        load_valid;
    logic        access_fault;
    logic        dm_r_enable;
    logic        dm_w_enable;
    logic [31:0] dm_address;
    logic [31:0] dm_wr_data;
    logic [31:0] dm_re_data;

    modport slave (
        input  mem_read, mem_write, funct3, addr, store_data, dm_re_data,
        output stall, load_data, load_valid, access_fault,
        output dm_r_enable, dm_w_enable, dm_address, dm_wr_data
    );

    modport master (
        output mem_read, mem_write, funct3, addr, store_data, dm_re_data,
        input  stall, load_data, load_valid, access_fault,
        input  dm_r_enable, dm_w_enable, dm_address, dm_wr_data
    );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit. It converts RV32I byte, halfword and word accesses
// into word-only accesses on data_mem.
// Ports:
//   clk   - rising-edge clock
//   rst_n - synchronous active-low reset
//   bus   - mem_access_unit_if.slave. It carries the requests from EX/MEM, the
//           combinational stall, the registered load result and fault pulse,
//           and the word interface to data_mem.
// Loads finish in one cycle. SW writes in its accepting cycle. SB and SH read
// the word, merge the new lane, and write it back the next cycle. The unit
// stalls the pipeline during the read cycle.
module mem_access_unit (
    input  logic              clk,
    input  logic              rst_n,
    mem_access_unit_if.slave  bus
);
    typedef enum logic {IDLE, RMW_WR} state_t;

    state_t      state;
    logic [31:0] load_data_q;
    logic        load_valid_q;
    logic        fault_q;
    logic [31:0] merge_q;
    logic [31:0] addr_q;

    logic        is_load;
    logic        req;
    logic        legal;
    logic        accept;
    logic        ld_go;
    logic        sw_go;
    logic        rmw_go;
    logic        rmw_wr;
    logic [31:0] word_addr;

    // Select the addressed lane of a word and extend it to 32 bits.
    // B/H are sign-extended, BU/HU are zero-extended, W passes through.
    function automatic logic [31:0] extend_load(input logic [31:0] word,
                                                input logic [2:0]  f3,
                                                input logic [1:0]  off);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic [31:0]        sh;
        sh = word >> {off, 3'b000};
        b  = signed'(sh[7:0]);
        h  = signed'(sh[15:0]);
        case (f3)
            3'b000:  extend_load = 32'(b);
            3'b001:  extend_load = 32'(h);
            3'b100:  extend_load = {24'd0, sh[7:0]};
            3'b101:  extend_load = {16'd0, sh[15:0]};
            default: extend_load = word;
        endcase
    endfunction

    // Replace the addressed byte (f3=000) or halfword (f3=001) of word with
    // the low bits of sd.
    function automatic logic [31:0] merge_store(input logic [31:0] word,
                                                input logic [31:0] sd,
                                                input logic [2:0]  f3,
                                                input logic [1:0]  off);
        logic [31:0] mask;
        logic [31:0] data;
        if (f3 == 3'b000) begin
            mask = 32'h0000_00FF << {off, 3'b000};
            data = {24'd0, sd[7:0]} << {off, 3'b000};
        end else begin
            mask = 32'h0000_FFFF << {off[1], 4'b0000};
            data = {16'd0, sd[15:0]} << {off[1], 4'b0000};
        end
        merge_store = (word & ~mask) | (data & mask);
    endfunction

    always_comb begin
        logic f3_ok;
        logic misalign;
        f3_ok    = 1'b0;
        misalign = 1'b0;
        case (bus.funct3)
            3'b000, 3'b100: f3_ok = 1'b1;
            3'b001, 3'b101: begin
                f3_ok    = 1'b1;
                misalign = bus.addr[0];
            end
            3'b010: begin
                f3_ok    = 1'b1;
                misalign = |bus.addr[1:0];
            end
            default: f3_ok = 1'b0;
        endcase
        // A store wins when both request bits are set.
        is_load = bus.mem_read & ~bus.mem_write;
        req     = bus.mem_read | bus.mem_write;
        // BU and HU exist only as loads.
        legal   = f3_ok & ~misalign & ~(bus.mem_write & bus.funct3[2]);
    end

    // The reset gate keeps stall and the data_mem enables low while rst_n is
    // low. It also drops a write pending in RMW_WR.
    assign accept    = rst_n & (state == IDLE) & req & legal;
    assign ld_go     = accept & is_load;
    assign sw_go     = accept & bus.mem_write & (bus.funct3 == 3'b010);
    assign rmw_go    = accept & bus.mem_write & (bus.funct3 != 3'b010);
    assign rmw_wr    = rst_n & (state == RMW_WR);
    assign word_addr = {bus.addr[31:2], 2'b00};

    assign bus.stall        = rmw_go;
    assign bus.dm_r_enable  = ld_go | rmw_go;
    assign bus.dm_w_enable  = sw_go | rmw_wr;
    assign bus.dm_address   = (state == RMW_WR) ? addr_q : word_addr;
    assign bus.dm_wr_data   = rmw_wr ? merge_q : (sw_go ? bus.store_data : 32'd0);
    assign bus.load_data    = load_data_q;
    assign bus.load_valid   = load_valid_q;
    assign bus.access_fault = fault_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            load_data_q  <= 32'd0;
            load_valid_q <= 1'b0;
            fault_q      <= 1'b0;
            merge_q      <= 32'd0;
            addr_q       <= 32'd0;
        end else begin
            load_valid_q <= ld_go;
            // A fault is raised only for a request seen in IDLE. Inputs are
            // ignored during RMW_WR.
            fault_q      <= (state == IDLE) & req & ~legal;
            if (ld_go)
                load_data_q <= extend_load(bus.dm_re_data, bus.funct3, bus.addr[1:0]);
            case (state)
                IDLE: begin
                    if (rmw_go) begin
                        merge_q <= merge_store(bus.dm_re_data, bus.store_data,
                                               bus.funct3, bus.addr[1:0]);
                        addr_q  <= word_addr;
                        state   <= RMW_WR;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit. The bench includes a 32-word data_mem
// model: reads are combinational and writes land on the rising edge.
module tb_mem_access_unit;
    logic clk;
    logic rst_n;
    int   errors;
    int   checks;
    logic [31:0] mem [32];

    mem_access_unit_if bus ();

    mem_access_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.dm_re_data = mem[bus.dm_address[6:2]];

    always @(posedge clk)
        if (bus.dm_w_enable)
            mem[bus.dm_address[6:2]] <= bus.dm_wr_data;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.funct3     = 3'b000;
        bus.addr       = 32'd0;
        bus.store_data = 32'd0;
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] sd);
        bus.mem_read   = rd;
        bus.mem_write  = wr;
        bus.funct3     = f3;
        bus.addr       = a;
        bus.store_data = sd;
        #1;
    endtask

    task automatic do_sw(input logic [31:0] a, input logic [31:0] sd);
        drive(1'b0, 1'b1, 3'b010, a, sd);
        check("sw_stall", {31'd0, bus.stall}, 32'd0);
        check("sw_wen", {31'd0, bus.dm_w_enable}, 32'd1);
        check("sw_wdata", bus.dm_wr_data, sd);
        tick();
        idle_inputs();
    endtask

    task automatic do_load(input string tag, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] exp);
        drive(1'b1, 1'b0, f3, a, 32'd0);
        check({tag, "_ren"}, {31'd0, bus.dm_r_enable}, 32'd1);
        check({tag, "_stall"}, {31'd0, bus.stall}, 32'd0);
        tick();
        idle_inputs();
        check({tag, "_valid"}, {31'd0, bus.load_valid}, 32'd1);
        check({tag, "_data"}, bus.load_data, exp);
        check({tag, "_fault"}, {31'd0, bus.access_fault}, 32'd0);
    endtask

    task automatic do_sub_store(input string tag, input logic [2:0] f3,
                                input logic [31:0] a, input logic [31:0] sd,
                                input logic [31:0] merged);
        drive(1'b0, 1'b1, f3, a, sd);
        check({tag, "_stall1"}, {31'd0, bus.stall}, 32'd1);
        check({tag, "_ren"}, {31'd0, bus.dm_r_enable}, 32'd1);
        check({tag, "_wen1"}, {31'd0, bus.dm_w_enable}, 32'd0);
        tick();
        idle_inputs();
        #1;
        check({tag, "_stall2"}, {31'd0, bus.stall}, 32'd0);
        check({tag, "_wen2"}, {31'd0, bus.dm_w_enable}, 32'd1);
        check({tag, "_waddr"}, bus.dm_address, {a[31:2], 2'b00});
        check({tag, "_wdata"}, bus.dm_wr_data, merged);
        tick();
        check({tag, "_wen3"}, {31'd0, bus.dm_w_enable}, 32'd0);
        check({tag, "_mem"}, mem[a[6:2]], merged);
    endtask

    task automatic do_fault(input string tag, input logic rd, input logic wr,
                            input logic [2:0] f3, input logic [31:0] a);
        drive(rd, wr, f3, a, 32'h0000_00FF);
        check({tag, "_wen"}, {31'd0, bus.dm_w_enable}, 32'd0);
        check({tag, "_stall"}, {31'd0, bus.stall}, 32'd0);
        tick();
        idle_inputs();
        check({tag, "_fault"}, {31'd0, bus.access_fault}, 32'd1);
        check({tag, "_valid"}, {31'd0, bus.load_valid}, 32'd0);
        tick();
        check({tag, "_fault_end"}, {31'd0, bus.access_fault}, 32'd0);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        for (int i = 0; i < 32; i++) mem[i] = 32'd0;
        idle_inputs();
        rst_n = 1'b0;
        // A sub-word store request held in reset must not stall or touch memory.
        drive(1'b0, 1'b1, 3'b000, 32'h10, 32'h11);
        check("rst_stall", {31'd0, bus.stall}, 32'd0);
        check("rst_ren", {31'd0, bus.dm_r_enable}, 32'd0);
        check("rst_wen", {31'd0, bus.dm_w_enable}, 32'd0);
        tick();
        tick();
        idle_inputs();
        check("rst_load_data", bus.load_data, 32'd0);
        check("rst_load_valid", {31'd0, bus.load_valid}, 32'd0);
        check("rst_fault", {31'd0, bus.access_fault}, 32'd0);
        rst_n = 1'b1;
        tick();

        do_sw(32'h10, 32'hDEAD_BEEF);
        check("sw_mem", mem[4], 32'hDEAD_BEEF);
        do_load("lw10", 3'b010, 32'h10, 32'hDEAD_BEEF);
        tick();
        check("valid_pulse", {31'd0, bus.load_valid}, 32'd0);
        check("load_hold", bus.load_data, 32'hDEAD_BEEF);

        do_load("lb13", 3'b000, 32'h13, 32'hFFFF_FFDE);
        do_load("lbu13", 3'b100, 32'h13, 32'h0000_00DE);
        do_load("lh12", 3'b001, 32'h12, 32'hFFFF_DEAD);
        do_load("lhu10", 3'b101, 32'h10, 32'h0000_BEEF);

        do_sub_store("sb11", 3'b000, 32'h11, 32'h0000_0055, 32'hDEAD_55EF);
        do_load("lw_fwd", 3'b010, 32'h10, 32'hDEAD_55EF);

        do_sub_store("sh12", 3'b001, 32'h12, 32'h0000_1234, 32'h1234_55EF);
        do_sub_store("sh10", 3'b001, 32'h10, 32'h0000_ABCD, 32'h1234_ABCD);
        do_load("lb10", 3'b000, 32'h10, 32'hFFFF_FFCD);
        do_load("lh12p", 3'b001, 32'h12, 32'h0000_1234);

        // Back-to-back loads give consecutive load_valid pulses.
        drive(1'b1, 1'b0, 3'b010, 32'h10, 32'd0);
        tick();
        check("b2b_valid1", {31'd0, bus.load_valid}, 32'd1);
        check("b2b_data1", bus.load_data, 32'h1234_ABCD);
        drive(1'b1, 1'b0, 3'b100, 32'h11, 32'd0);
        tick();
        idle_inputs();
        check("b2b_valid2", {31'd0, bus.load_valid}, 32'd1);
        check("b2b_data2", bus.load_data, 32'h0000_00AB);
        tick();
        check("b2b_valid_end", {31'd0, bus.load_valid}, 32'd0);

        // mem_read together with mem_write acts as a store.
        drive(1'b1, 1'b1, 3'b010, 32'h18, 32'h0BAD_F00D);
        check("both_wen", {31'd0, bus.dm_w_enable}, 32'd1);
        check("both_ren", {31'd0, bus.dm_r_enable}, 32'd0);
        tick();
        idle_inputs();
        check("both_valid", {31'd0, bus.load_valid}, 32'd0);
        check("both_mem", mem[6], 32'h0BAD_F00D);

        do_fault("f_lw12", 1'b1, 1'b0, 3'b010, 32'h12);
        do_fault("f_sh11", 1'b0, 1'b1, 3'b001, 32'h11);
        do_fault("f_f3_011", 1'b1, 1'b0, 3'b011, 32'h10);
        do_fault("f_sbu", 1'b0, 1'b1, 3'b100, 32'h14);
        check("f_mem14", mem[5], 32'd0);

        // Reset asserted in the RMW_WR cycle of SB 0xAA @0x14.
        drive(1'b0, 1'b1, 3'b000, 32'h14, 32'h0000_00AA);
        check("rrmw_stall", {31'd0, bus.stall}, 32'd1);
        tick();
        idle_inputs();
        rst_n = 1'b0;
        #1;
        check("rrmw_wen", {31'd0, bus.dm_w_enable}, 32'd0);
        tick();
        check("rrmw_mem", mem[5], 32'd0);
        check("rrmw_load_data", bus.load_data, 32'd0);
        check("rrmw_valid", {31'd0, bus.load_valid}, 32'd0);
        check("rrmw_fault", {31'd0, bus.access_fault}, 32'd0);
        rst_n = 1'b1;
        #1;
        check("rrmw_idle_wen", {31'd0, bus.dm_w_enable}, 32'd0);
        tick();
        check("rrmw_mem2", mem[5], 32'd0);
        do_load("rrmw_lw", 3'b010, 32'h14, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store unit for the pipeline's MEM stage. It sits between the EX/MEM pipeline register and the 32-word `data_mem`, and turns RV32I byte, halfword and word accesses into the word-only read/write interface of `data_mem`. Loads are extracted and sign- or zero-extended into a registered result. Sub-word stores run as a two-cycle read-modify-write and stall the pipeline for one cycle.

## Interface
No parameters; the data width is fixed at 32 bits.
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- mem_read  in  1  load request from EX/MEM
- mem_write  in  1  store request from EX/MEM; takes priority if both are set
- funct3  in  3  access type: 000 B, 001 H, 010 W, 100 BU (load only), 101 HU (load only)
- addr  in  32  byte address
- store_data  in  32  store operand; the byte/half is taken from its low bits
- stall  out  1  combinational; holds EX/MEM and earlier stages this cycle
- load_data  out  32  registered, extended load result
- load_valid  out  1  registered one-cycle pulse when load_data is updated
- access_fault  out  1  registered one-cycle pulse on a misaligned or illegal access
- dm_r_enable  out  1  to data_mem r_enable
- dm_w_enable  out  1  to data_mem w_enable
- dm_address  out  32  to data_mem address; always word-aligned ({addr[31:2],2'b00})
- dm_wr_data  out  32  to data_mem wr_data
- dm_re_data  in  32  from data_mem re_data; combinational read

## Operation
- FSM states:
  - IDLE: accepts requests.
  - RMW_WR: writes back the merged word; inputs are ignored in this state.
- Legality checks:
  - H and HU need addr[0]=0.
  - W needs addr[1:0]=0.
  - funct3 011, 110 and 111 are illegal.
  - BU or HU with mem_write is illegal.
  - An illegal or misaligned request does no memory access and causes access_fault=1 next cycle.
- Load (IDLE, mem_read, legal):
  - dm_r_enable=1 for that cycle.
  - The lane is selected by addr[1:0]: byte lane = 8*addr[1:0], half lane = 16*addr[1].
  - The selected lane is extended (B/H sign-extend, BU/HU zero-extend, W unchanged) and registered into load_data.
  - load_valid=1 next cycle.
  - No stall.
- SW (IDLE, legal): dm_w_enable=1 and dm_wr_data=store_data in the same cycle. No stall.
- SB/SH (IDLE, legal):
  - dm_r_enable=1 and stall=1.
  - The selected lane of dm_re_data is replaced with store_data[7:0] or store_data[15:0].
  - The merged word is registered into merge_q and the word address into addr_q.
  - Next state is RMW_WR.
- RMW_WR: dm_w_enable=1, dm_address=addr_q, dm_wr_data=merge_q, stall=0. Next state is IDLE.
- Outputs when no request is active: all dm_* enables are 0, dm_wr_data=0, and dm_address follows addr aligned.
- load_data holds its last value between loads.

## Timing
- Reset (rst_n=0 at a clk edge):
  - state=IDLE.
  - load_data=0, load_valid=0, access_fault=0, merge_q=0, addr_q=0.
  - stall=0 and all dm_* enables are 0 while rst_n=0.
- Load latency: 1 cycle, request edge to load_valid. Throughput is 1 load per cycle; back-to-back loads produce consecutive load_valid pulses.
- SW: 1 cycle, committed at the accepting edge.
- SB/SH: 2 cycles.
  - stall is high in the accepting cycle only.
  - Upstream holds the request through that cycle.
  - Memory is updated at the end of the RMW_WR cycle.
- Forwarding: a load in the cycle after an RMW_WR sees the written word, because the write lands at the edge and the memory read is combinational.
- Reset asserted during RMW_WR: the pending write is dropped and the memory word is left unchanged.
- A fault pulse and load_valid are never high together.
- mem_read and mem_write both set: treated as a store.

## Test plan
- SW 0xDEADBEEF @0x10, then LW @0x10: load_valid pulse one cycle after the LW; load_data=0xDEADBEEF; no stall.
- With word @0x10 = 0xDEADBEEF:
  - LB @0x13 gives 0xFFFFFFDE.
  - LBU @0x13 gives 0x000000DE.
  - LH @0x12 gives 0xFFFFDEAD.
  - LHU @0x10 gives 0x0000BEEF.
- SB 0x55 @0x11 with word 0xDEADBEEF:
  - stall=1 for exactly one cycle; dm_w_enable high in the following cycle only.
  - Memory word becomes 0xDEAD55EF.
  - An immediately following LW returns 0xDEAD55EF.
- SH 0x1234 @0x12, then SH 0xABCD @0x10 back-to-back: each stalls one cycle; final word = 0x1234ABCD.
- LW @0x12, SH @0x11, funct3=011, and SBU: each gives access_fault=1 for one cycle, with no dm_w_enable, no load_valid and no stall.
- Assert rst_n=0 in the RMW_WR cycle of SB 0xAA @0x14 with word 0x00000000: the word stays 0x00000000, state returns to IDLE, and all registered outputs are 0.
